spi_slave_regfile: RTL and testbench
====================================

# spi_slave_regfile

SPI target that sits at the far end of the team's SPI master link: it consumes sclk/ss/mosi and drives miso. It decodes a one-byte command followed by data bytes into reads and writes of a 2^ADDR_W x 8 register file, which is also exposed to local fabric. All shifting is LSB-first, mode 0: capture on rising sclk, launch on falling sclk.

## Interface
- ADDR_W, 4: register address width; file depth 2^ADDR_W (max 6).
- REG_INIT, 8'h00: reset value of every register.
- DEV_ID, 7'h5A: constant returned in status byte bits[6:0].
- sclk  in  1  serial clock; only toggles while ss is low.
- rst  in  1  reset, synchronous to sclk, active-low.
- ss  in  1  slave select, active-low; high asynchronously ends the frame.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master; 1'bz while ss is high.
- host_addr  in  ADDR_W  fabric read address.
- host_rdata  out  8  combinational reg[host_addr].
- wr_toggle  out  1  inverts once per completed SPI write.
- wr_addr  out  ADDR_W  address of the last SPI write; held.
- wr_data  out  8  data of the last SPI write; held.
- frame_err  out  1  sticky; set when a frame ends mid-byte.

## Operation
- Command byte, first after ss falls, LSB first:
  - bits[ADDR_W-1:0]: start address.
  - bit6: auto-increment (AI).
  - bit7: 1 = write, 0 = read.
  - Bits between ADDR_W and 5 are ignored.
- States:
  - CMD goes to WR after 8 bits when bit7 = 1.
  - CMD goes to RD after 8 bits when bit7 = 0.
  - WR and RD stay in their state until the frame ends.
  - ss high ends the frame. The next frame always begins in CMD.
- bit_cnt (3 bits) counts rising edges within the current byte and wraps 7 to 0 at each byte boundary.
- WR, per completed data byte:
  - reg[addr] <= byte.
  - wr_addr <= addr, wr_data <= byte.
  - wr_toggle inverts.
  - addr increments if AI is set.
- RD:
  - Each data byte shifts out the value reg[addr] had at the preceding byte boundary.
  - addr increments after each byte if AI is set.
  - With AI clear, the same register repeats.
- During CMD, miso shifts out the status byte {frame_err, DEV_ID}.
- Address wraps from 2^ADDR_W-1 to 0 with AI.
- Frame end:
  - ss high asynchronously sets new_frame. The state returns to CMD.
  - bit_cnt holds its value until the next frame.
  - At the first rising edge of the next frame (new_frame = 1):
    - If the held bit_cnt != 0, frame_err <= 1.
    - bit_cnt then restarts from bit 0 and new_frame clears.
  - A partial byte is discarded: no write occurs.
- frame_err clears only on rst.
- A write and a same-address host read in the same cycle: host_rdata shows the new value after the rising edge.

## Timing
- Rising sclk:
  - sample mosi
  - advance bit_cnt and state
  - perform register writes and update the wr_* outputs
- Falling sclk: miso launches the next bit.
- miso first-bit rules:
  - Bit 0 of each data byte launches on the falling edge after the previous byte's 8th rising edge.
  - Bit 0 of the status byte is driven combinationally while ss is low and new_frame = 1.
- Write commit latency: the 8th rising edge of the data byte. wr_toggle changes on that edge.
- Fabric handshake:
  - Fabric synchronises wr_toggle to its own clock.
  - Fabric samples wr_addr and wr_data after the edge.
  - Both are stable until the next write.
- rst is sampled only on a rising sclk. When sampled low:
  - all registers = REG_INIT
  - state = CMD, bit_cnt = 0, new_frame = 1
  - frame_err = 0, wr_toggle = 0, wr_addr = 0, wr_data = 0
  - miso launch register = 0
- rst mid-frame: the rest of that frame is treated as a new frame starting in CMD.
- Reset outputs:
  - miso = z while ss is high. Otherwise it is status bit 0 (DEV_ID[0]).
  - host_rdata = REG_INIT.

## Test plan
- Write: send 8'h83 then 8'h3C, LSB first. Required:
  - reg[3] = 8'h3C, wr_addr = 3, wr_data = 8'h3C.
  - wr_toggle flips once.
  - host_addr = 3 gives 8'h3C.
- Status and read: after the write above, send 8'h03 then 8'h00. Required:
  - miso byte 0 = 8'h5A (status, frame_err = 0).
  - miso byte 1 = 8'h3C.
- Auto-increment wrap: send 8'hCF, 8'h11, 8'h22. Required: reg[15] = 8'h11, reg[0] = 8'h22, wr_toggle flips twice.
- Aborted frame:
  - Send 8'h81, then raise ss after 5 data bits.
  - Required: reg[1] is unchanged.
  - Next frame command byte 8'h01 returns status 8'hDA (frame_err = 1).
- Reset mid-frame:
  - Pull rst low for one rising edge during a write data byte.
  - Required: all registers = REG_INIT, frame_err = 0, wr_toggle = 0, state = CMD.
- Repeat read without AI: send 8'h05 followed by 3 data bytes with reg[5] = 8'hA7. Required: miso data bytes = A7, A7, A7.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 target (LSB-first) fronting a 2^ADDR_W x 8 register file.
// Byte 0 of a frame is a command {wr, ai, -, addr}; following bytes are data.
// The register file is also readable combinationally by local fabric.
module spi_slave_regfile #(
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  REG_INIT = 8'h00,
  parameter logic [6:0]  DEV_ID   = 7'h5A
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_rdata,
  output logic              wr_toggle,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {CMD, WR, RD} state_t;

  state_t                     state_q, state_d, st_eff;
  logic [2:0]                 bit_cnt_q, bit_cnt_d, cnt_eff;
  logic                       new_frame_q, new_frame_d;
  logic [6:0]                 sh_q, sh_d;
  logic [7:0]                 byte_w;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic                       ai_q, ai_d;
  logic [7:0]                 tx_q, tx_d;
  logic [DEPTH-1:0][7:0]      regs_q, regs_d;
  logic                       frame_err_q, frame_err_d;
  logic                       wr_toggle_q, wr_toggle_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [7:0]                 wr_data_q, wr_data_d;
  logic                       miso_q, miso_d;

  // Rising-edge next state: a pending new_frame overrides the held state and
  // bit count, so the frame always restarts in CMD at bit 0.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    new_frame_d = new_frame_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    ai_d        = ai_q;
    tx_d        = tx_q;
    regs_d      = regs_q;
    frame_err_d = frame_err_q;
    wr_toggle_d = wr_toggle_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    st_eff      = new_frame_q ? CMD : state_q;
    cnt_eff     = new_frame_q ? 3'd0 : bit_cnt_q;
    byte_w      = {mosi, sh_q};
    if (!rst) begin
      state_d     = CMD;
      bit_cnt_d   = 3'd0;
      new_frame_d = 1'b1;
      sh_d        = '0;
      addr_d      = '0;
      ai_d        = 1'b0;
      tx_d        = '0;
      regs_d      = {DEPTH{REG_INIT}};
      frame_err_d = 1'b0;
      wr_toggle_d = 1'b0;
      wr_addr_d   = '0;
      wr_data_d   = '0;
    end else begin
      new_frame_d = 1'b0;
      state_d     = st_eff;
      bit_cnt_d   = cnt_eff + 3'd1;
      sh_d        = {mosi, sh_q[6:1]};
      if (new_frame_q) begin
        // held count non-zero means the previous frame stopped mid-byte
        if (bit_cnt_q != 3'd0) frame_err_d = 1'b1;
        tx_d = {frame_err_d, DEV_ID};
      end
      if (cnt_eff == 3'd7) begin
        case (st_eff)
          CMD: begin
            addr_d = byte_w[ADDR_W-1:0];
            ai_d   = byte_w[6];
            if (byte_w[7]) begin
              state_d = WR;
              tx_d    = '0;
            end else begin
              state_d = RD;
              tx_d    = regs_q[byte_w[ADDR_W-1:0]];
            end
          end
          WR: begin
            regs_d[addr_q] = byte_w;
            wr_addr_d      = addr_q;
            wr_data_d      = byte_w;
            wr_toggle_d    = ~wr_toggle_q;
            addr_d         = addr_q + {{(ADDR_W-1){1'b0}}, ai_q};
          end
          RD: begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, ai_q};
            tx_d   = regs_q[addr_d];
          end
          default: ;
        endcase
      end
    end
  end

  // Main rising-edge state; rst is synchronous.
  always_ff @(posedge sclk) begin
    state_q     <= state_d;
    bit_cnt_q   <= bit_cnt_d;
    sh_q        <= sh_d;
    addr_q      <= addr_d;
    ai_q        <= ai_d;
    tx_q        <= tx_d;
    regs_q      <= regs_d;
    frame_err_q <= frame_err_d;
    wr_toggle_q <= wr_toggle_d;
    wr_addr_q   <= wr_addr_d;
    wr_data_q   <= wr_data_d;
  end

  // new_frame is set asynchronously by ss going high and cleared on the first edge.
  always_ff @(posedge sclk or posedge ss) begin
    if (ss) new_frame_q <= 1'b1;
    else    new_frame_q <= new_frame_d;
  end

  // Falling-edge launch selects the bit the master samples on the next rise.
  always_comb miso_d = tx_q[bit_cnt_q];

  // miso launch register.
  always_ff @(negedge sclk) miso_q <= miso_d;

  assign miso       = ss ? 1'bz : (new_frame_q ? DEV_ID[0] : miso_q);
  assign host_rdata = regs_q[host_addr];
  assign wr_toggle  = wr_toggle_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: directed SPI frames, scoreboard queues for
// miso bytes and write notifications, monitors pop and compare.
module tb_spi_slave_regfile;
  logic       sclk, rst, ss, mosi;
  logic       miso;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_toggle;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  exp_miso[$];  // {care, byte}
  logic [11:0] exp_wr[$];    // {addr, data}
  event        smp_ev;

  spi_slave_regfile #(.ADDR_W(4), .REG_INIT(8'h00), .DEV_ID(7'h5A)) dut (
    .sclk(sclk), .rst(rst), .ss(ss), .mosi(mosi), .miso(miso),
    .host_addr(host_addr), .host_rdata(host_rdata), .wr_toggle(wr_toggle),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err));

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic hrd(input logic [3:0] a, input logic [7:0] e);
    host_addr = a;
    #1;
    chk($sformatf("host_rdata[%0d]", a), host_rdata, e);
  endtask

  // one SPI bit: data set while sclk low, sample strobe, rising edge, falling edge
  task automatic sbit(input logic b);
    mosi = b;
    #4;
    -> smp_ev;
    #1 sclk = 1'b1;
    #5 sclk = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] v, input logic care, input logic [7:0] e);
    exp_miso.push_back({care, e});
    for (int i = 0; i < 8; i++) sbit(v[i]);
  endtask

  task automatic fbegin();
    ss = 1'b0;
    #5;
  endtask

  task automatic fend();
    #5 ss = 1'b1;
    #10;
  endtask

  // miso monitor: assemble LSB-first bytes per frame, drop partial bytes
  initial begin
    int         mbit;
    logic [7:0] mbyte;
    logic [8:0] e;
    mbit  = 0;
    mbyte = '0;
    forever begin
      @(smp_ev or posedge ss);
      if (ss === 1'b1) mbit = 0;
      else begin
        mbyte[mbit[2:0]] = miso;
        mbit++;
        if (mbit == 8) begin
          mbit = 0;
          if (exp_miso.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL miso_unexpected: got %h expected none", mbyte);
          end else begin
            e = exp_miso.pop_front();
            if (e[8]) chk("miso_byte", mbyte, e[7:0]);
          end
        end
      end
    end
  end

  // write monitor: each wr_toggle flip outside reset reports one write
  initial begin
    logic [11:0] e;
    forever begin
      @(wr_toggle);
      #1;
      if (rst === 1'b1) begin
        n_tests++;
        if (exp_wr.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: got %h/%h expected none", wr_addr, wr_data);
        end else begin
          e = exp_wr.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            n_fail++;
            $display("FAIL wr_notify: got %h/%h expected %h/%h", wr_addr, wr_data, e[11:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    sclk = 1'b0; rst = 1'b0; ss = 1'b1; mosi = 1'b0; host_addr = '0;
    #5;
    repeat (2) begin #5 sclk = 1'b1; #5 sclk = 1'b0; end
    rst = 1'b1;
    #5;

    // reset state
    chk("rst_frame_err", {7'b0, frame_err}, 8'h00);
    chk("rst_wr_toggle", {7'b0, wr_toggle}, 8'h00);
    for (int a = 0; a < 16; a++) hrd(4'(a), 8'h00);
    n_tests++;
    if (miso !== 1'bz) begin n_fail++; $display("FAIL miso_idle_z: got %b expected z", miso); end
    ss = 1'b0; #1;
    n_tests++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL miso_status_bit0: got %b expected 0", miso); end
    ss = 1'b1; #5;

    // write reg3 = 3C
    fbegin(); sbyte(8'h83, 1'b1, 8'h5A);
    exp_wr.push_back({4'h3, 8'h3C}); sbyte(8'h3C, 1'b0, 8'h00); fend();
    hrd(4'd3, 8'h3C);
    chk("wr_addr", {4'b0, wr_addr}, 8'h03);
    chk("wr_data", wr_data, 8'h3C);
    chk("wr_toggle_1", {7'b0, wr_toggle}, 8'h01);

    // status + read reg3
    fbegin(); sbyte(8'h03, 1'b1, 8'h5A); sbyte(8'h00, 1'b1, 8'h3C); fend();

    // auto-increment write wrapping 15 -> 0
    fbegin(); sbyte(8'hCF, 1'b1, 8'h5A);
    exp_wr.push_back({4'hF, 8'h11}); sbyte(8'h11, 1'b0, 8'h00);
    exp_wr.push_back({4'h0, 8'h22}); sbyte(8'h22, 1'b0, 8'h00); fend();
    hrd(4'd15, 8'h11);
    hrd(4'd0, 8'h22);
    chk("wr_toggle_3", {7'b0, wr_toggle}, 8'h01);

    // aborted frame: 5 data bits then ss high
    fbegin(); sbyte(8'h81, 1'b1, 8'h5A);
    for (int i = 0; i < 5; i++) sbit(1'b1);
    fend();
    hrd(4'd1, 8'h00);
    chk("frame_err_pending", {7'b0, frame_err}, 8'h00);
    fbegin(); sbyte(8'h01, 1'b1, 8'hDA); sbyte(8'h00, 1'b1, 8'h00); fend();
    chk("frame_err_set", {7'b0, frame_err}, 8'h01);

    // repeated read without AI
    fbegin(); sbyte(8'h85, 1'b1, 8'hDA);
    exp_wr.push_back({4'h5, 8'hA7}); sbyte(8'hA7, 1'b0, 8'h00); fend();
    fbegin(); sbyte(8'h05, 1'b1, 8'hDA);
    repeat (3) sbyte(8'h00, 1'b1, 8'hA7);
    fend();
    chk("wr_toggle_4", {7'b0, wr_toggle}, 8'h00);

    // reset pulled during a write data byte
    fbegin(); sbyte(8'h81, 1'b1, 8'hDA);
    exp_wr.push_back({4'h1, 8'h5B}); sbyte(8'h5B, 1'b0, 8'h00);
    chk("wr_toggle_5", {7'b0, wr_toggle}, 8'h01);
    sbit(1'b1); sbit(1'b0); sbit(1'b1);
    rst = 1'b0; sbit(1'b0); rst = 1'b1;
    fend();
    for (int a = 0; a < 16; a++) hrd(4'(a), 8'h00);
    chk("rst2_frame_err", {7'b0, frame_err}, 8'h00);
    chk("rst2_wr_toggle", {7'b0, wr_toggle}, 8'h00);
    chk("rst2_wr_addr", {4'b0, wr_addr}, 8'h00);
    chk("rst2_wr_data", wr_data, 8'h00);
    fbegin(); sbyte(8'h05, 1'b1, 8'h5A); sbyte(8'h00, 1'b1, 8'h00); fend();

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 100; i++) begin
      if (exp_miso.size() == 0 && exp_wr.size() == 0) break;
      #10;
    end
    n_tests++;
    if (exp_miso.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", exp_miso.size(), exp_wr.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
